// File: rtl/freelist.sv
// Circular free list of physical register tags: allocate at the head, return at the tail.
// Optional single-level head checkpoint/restore is built when FREELIST_CKPT_EN is defined.
module freelist #(
    parameter int WIDTH = 6,
    parameter int SIZE  = 32,
    parameter int FIRST = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    output logic [WIDTH-1:0]          o_tag,
    output logic                      o_valid,
    input  logic                      i_alloc,
    input  logic                      i_free,
    input  logic [WIDTH-1:0]          i_free_tag,
    output logic [$clog2(SIZE):0]     o_count,
    output logic                      o_empty,
    output logic                      o_full,
    input  logic                      i_ckpt,
    input  logic                      i_restore
);
    localparam int IW = $clog2(SIZE);
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    w_count;
    logic [PW-1:0]    w_head_inc;
    logic [PW-1:0]    w_head_nxt;
    logic             w_restore;
    logic             w_alloc_ok;
    logic             w_free_ok;

    assign w_count = r_tail - r_head;
    assign o_count = w_count;
    assign o_empty = (w_count == '0);
    assign o_full  = (w_count == PW'(SIZE));
    assign o_valid = !o_empty;
    assign o_tag   = r_mem[r_head[IW-1:0]];

    assign w_alloc_ok = i_alloc && !o_empty && !w_restore;
    // A simultaneous alloc frees a slot, so a free into a full list still fits.
    assign w_free_ok  = i_free && (!o_full || w_alloc_ok);
    assign w_head_inc = r_head + PW'(w_alloc_ok);

`ifdef FREELIST_CKPT_EN
    logic [PW-1:0] r_ckpt;

    assign w_restore  = i_restore;
    assign w_head_nxt = w_restore ? r_ckpt : w_head_inc;

    // Restore wins over a same-cycle checkpoint, leaving the saved head intact.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ckpt <= '0;
        end else if (i_ckpt && !i_restore) begin
            r_ckpt <= w_head_inc;
        end
    end
`else
    logic w_unused;

    assign w_restore  = 1'b0;
    assign w_head_nxt = w_head_inc;
    assign w_unused   = i_ckpt ^ i_restore;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= PW'(SIZE);
        end else begin
            r_head <= w_head_nxt;
            if (w_free_ok) begin
                r_tail <= r_tail + PW'(1);
            end
        end
    end

    // Reset preloads every entry so the list comes up full of FIRST..FIRST+SIZE-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SIZE; k++) begin
                r_mem[k] <= WIDTH'(FIRST + k);
            end
        end else if (w_free_ok) begin
            r_mem[r_tail[IW-1:0]] <= i_free_tag;
        end
    end
endmodule

// File: tb/tb_freelist.sv
// Bench for freelist (SIZE=4, WIDTH=3, FIRST=4): queue model of the free tags plus a
// scoreboard of expected alloc tags; checkpoint scenarios follow FREELIST_CKPT_EN.
module tb_freelist;
    localparam int WIDTH = 3;
    localparam int SIZE  = 4;
    localparam int FIRST = 4;
`ifdef FREELIST_CKPT_EN
    localparam bit CKPT_EN = 1'b1;
`else
    localparam bit CKPT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [WIDTH-1:0] o_tag;
    logic             o_valid;
    logic             i_alloc = 1'b0;
    logic             i_free = 1'b0;
    logic [WIDTH-1:0] i_free_tag = '0;
    logic [2:0]       o_count;
    logic             o_empty;
    logic             o_full;
    logic             i_ckpt = 1'b0;
    logic             i_restore = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int model[$];
    int exp_q[$];
    int hist[$];

    always #5 clk = ~clk;

    freelist #(.WIDTH(WIDTH), .SIZE(SIZE), .FIRST(FIRST)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .o_tag      (o_tag),
        .o_valid    (o_valid),
        .i_alloc    (i_alloc),
        .i_free     (i_free),
        .i_free_tag (i_free_tag),
        .o_count    (o_count),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .i_ckpt     (i_ckpt),
        .i_restore  (i_restore)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check("count", int'(o_count), model.size());
        check("empty", int'(o_empty), int'(model.size() == 0));
        check("full",  int'(o_full),  int'(model.size() == SIZE));
        check("valid", int'(o_valid), int'(model.size() != 0));
    endtask

    task automatic model_reset();
        model.delete();
        for (int k = 0; k < SIZE; k++) model.push_back(FIRST + k);
        hist.delete();
        exp_q.delete();
    endtask

    // One clock cycle: drive, check the visible state, advance the model, then clock.
    task automatic cyc(input bit a, input bit f, input int t, input bit c, input bit r);
        bit full0, rst_eff, aok, fok;
        int tg;
        @(negedge clk);
        i_alloc = a; i_free = f; i_free_tag = WIDTH'(t); i_ckpt = c; i_restore = r;
        #1;
        check_state();
        full0   = (model.size() == SIZE);
        rst_eff = CKPT_EN && r;
        aok     = a && (model.size() > 0) && !rst_eff;
        fok     = f && (!full0 || aok);
        if (aok) begin
            tg = model.pop_front();
            exp_q.push_back(tg);
            check("tag", int'(o_tag), exp_q.pop_front());
            if (CKPT_EN) begin
                if (c) hist.delete();
                else   hist.push_back(tg);
            end
        end else if (CKPT_EN && c && !rst_eff) begin
            hist.delete();
        end
        if (rst_eff) begin
            model = {hist, model};
            hist.delete();
        end
        if (fok) model.push_back(t);
        @(posedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic alloc_n(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; values checked before any clock edge.
    task automatic do_reset(input bit inflight);
        @(negedge clk);
        i_alloc = inflight; i_free = inflight; i_free_tag = '0;
        i_ckpt = 1'b0; i_restore = 1'b0;
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_state();
        check("rst_tag", int'(o_tag), FIRST);
        @(negedge clk);
        i_alloc = 1'b0; i_free = 1'b0;
        i_rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset(1'b0);

        // Drain to empty, then an alloc while empty is ignored.
        alloc_n(4);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle();

        // Free into a full list is dropped.
        do_reset(1'b0);
        cyc(1'b0, 1'b1, 3, 1'b0, 1'b0);
        alloc_n(4);

        // Refill an empty list, wrapping the pointers.
        cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 6, 1'b0, 1'b0);
        alloc_n(2);
        idle();

        // Simultaneous alloc and free while full.
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1, 1'b0, 1'b0);
        alloc_n(4);
        idle();

        // Checkpoint with alloc, two more allocs, restore with alloc.
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0);
        alloc_n(2);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
        idle();
        alloc_n(1);
        // Restore alongside a free and a checkpoint request: free kept, checkpoint untouched.
        cyc(1'b0, 1'b1, 0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle();

        // Reset mid-sequence with an alloc and free in flight.
        do_reset(1'b0);
        alloc_n(2);
        do_reset(1'b1);
        alloc_n(4);

        // Random alloc/free traffic.
        do_reset(1'b0);
        for (int k = 0; k < 80; k++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), 1'b0, 1'b0);
        end
        idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
